// File: rtl/xsw_pkg.sv
// Shared types and helpers for the xsw arbitration mux: arbiter state
// encoding and the source-index width helper.
package xsw_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xsw_arb_mux_if.sv
// Stream bundle for xsw_arb_mux: N_SRC input streams in, one registered
// stream out. The slave modport is the arbiter's view, the master modport is the environment's view.
interface xsw_arb_mux_if
  import xsw_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int D_WIDTH = 16
);

  logic [N_SRC-1:0]         vldi;
  logic [N_SRC-1:0]         rdyi;
  logic [N_SRC*D_WIDTH-1:0] datai;
  logic [N_SRC-1:0]         lasti;
  logic                     vldo;
  logic                     rdyo;
  logic [D_WIDTH-1:0]       datao;
  logic                     lasto;
  logic [idx_w(N_SRC)-1:0]  grant_id;

  modport master (
    output vldi, datai, lasti, rdyo,
    input  rdyi, vldo, datao, lasto, grant_id
  );

  modport slave (
    input  vldi, datai, lasti, rdyo,
    output rdyi, vldo, datao, lasto, grant_id
  );

endinterface

// File: rtl/xsw_rr_pick.sv
// Combinational rotate-priority picker: the first requester after ptr
// (wrapping modulo N_SRC) wins. The outputs are a one-hot grant and the index of the winner.
module xsw_rr_pick
  import xsw_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]        req,
  input  logic [idx_w(N_SRC)-1:0] ptr,
  output logic [N_SRC-1:0]        gnt,
  output logic [idx_w(N_SRC)-1:0] idx
);

  localparam int IW = idx_w(N_SRC);

  logic [IW-1:0] cand;

  // Walk from the farthest offset down to ptr+1 so the nearest requester wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % N_SRC);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/xsw_arb_mux.sv
// Round-robin N_SRC:1 stream arbiter/mux with a registered output stage.
// Define XSW_ARB_PKT_LOCK_EN to hold the grant for a whole packet, until the accepted beat with lasti.
module xsw_arb_mux
  import xsw_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int D_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  xsw_arb_mux_if.slave bus
);

  localparam int IW = idx_w(N_SRC);

  logic               load;
  logic               accept;
  logic               acc_last;
  logic [D_WIDTH-1:0] acc_data;
  logic [N_SRC-1:0]   pick_gnt;
  logic [N_SRC-1:0]   sel_oh;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      sel_id;
  logic [IW-1:0]      ptr;

  logic               vld_p1;
  logic               last_p1;
  logic [D_WIDTH-1:0] data_p1;
  logic [IW-1:0]      gid_p1;

`ifdef XSW_ARB_PKT_LOCK_EN
  arb_state_e    state;
  logic [IW-1:0] lock_id;
`endif

  xsw_rr_pick #(.N_SRC(N_SRC)) u_pick (
    .req (bus.vldi),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // While locked, only the stored source may be granted; if it is idle, the cycle is a bubble.
  always_comb begin
    sel_oh = pick_gnt;
    sel_id = pick_idx;
`ifdef XSW_ARB_PKT_LOCK_EN
    if (state == LOCKED) begin
      sel_oh          = '0;
      sel_oh[lock_id] = bus.vldi[lock_id];
      sel_id          = lock_id;
    end
`endif
  end

  assign load     = ~vld_p1 | bus.rdyo;
  assign bus.rdyi = (load && !rst) ? sel_oh : '0;
  assign accept   = |(bus.vldi & bus.rdyi);

  always_comb begin
    acc_data = '0;
    acc_last = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel_oh[i]) begin
        acc_data = bus.datai[i*D_WIDTH +: D_WIDTH];
        acc_last = bus.lasti[i];
      end
    end
  end

  // Stage p1: output register. An empty load clears valid; payload and id hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
      gid_p1  <= '0;
    end else if (load) begin
      vld_p1 <= accept;
      if (accept) begin
        last_p1 <= acc_last;
        data_p1 <= acc_data;
        gid_p1  <= sel_id;
      end
    end
  end

  // Arbiter state: round-robin pointer plus, in lock mode, the packet lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= IW'(N_SRC - 1);
`ifdef XSW_ARB_PKT_LOCK_EN
      state   <= IDLE;
      lock_id <= '0;
`endif
    end else if (accept) begin
`ifdef XSW_ARB_PKT_LOCK_EN
      if (acc_last) begin
        state <= IDLE;
        ptr   <= sel_id;
      end else begin
        state   <= LOCKED;
        lock_id <= sel_id;
      end
`else
      ptr <= sel_id;
`endif
    end
  end

  assign bus.vldo     = vld_p1;
  assign bus.lasto    = last_p1;
  assign bus.datao    = data_p1;
  assign bus.grant_id = gid_p1;

endmodule

// File: doc/xsw_arb_mux.md
XSW_ARB_MUX -- requirements
Module: xsw_arb_mux

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of input streams (legal range 2..16).
REQ-002 SHALL have parameter D_WIDTH, default 16, payload width per beat.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port vldi  input  N_SRC  per-source valid.
REQ-006 SHALL have port rdyi  output  N_SRC  per-source ready.
REQ-007 SHALL have port datai  input  N_SRC*D_WIDTH  per-source payload; source i at bits [i*D_WIDTH +: D_WIDTH].
REQ-008 SHALL have port lasti  input  N_SRC  per-source end-of-packet flag.
REQ-009 SHALL have port vldo  output  1  output valid, to downstream register slice.
REQ-010 SHALL have port rdyo  input  1  downstream ready.
REQ-011 SHALL have port datao  output  D_WIDTH  selected payload.
REQ-012 SHALL have port lasto  output  1  selected end-of-packet flag.
REQ-013 SHALL have port grant_id  output  $clog2(N_SRC)  source index of the beat on datao.

Function
REQ-014 SHALL register all outputs: a beat accepted in cycle T appears on vldo/datao/lasto/grant_id in cycle T+1.
REQ-015 SHALL compute load = ~vldo | rdyo; the output register loads or clears only when load=1.
REQ-016 SHALL drive rdyi[i]=1 only for the single granted source, and only when load=1; at most one rdyi bit high per cycle.
REQ-017 SHALL accept from source i when vldi[i] & rdyi[i]; no other source is consumed that cycle.
REQ-018 SHALL, when load=1 and no beat is accepted, clear vldo to 0 while datao/lasto/grant_id hold their values.
REQ-019 SHALL hold vldo/datao/lasto/grant_id stable while vldo=1 and rdyo=0.
REQ-020 SHALL pick in state IDLE by round-robin: search starts at ptr+1 modulo N_SRC; first source with vldi=1 wins.
REQ-021 SHALL update ptr to the winning index on every beat accepted with lasti=1 (lock mode) or on every accepted beat (no-lock mode).
REQ-022 SHALL, in lock mode, enter state LOCKED on an accepted beat with lasti=0, storing the source index.
REQ-023 SHALL, in LOCKED, grant only the stored source regardless of other vldi; return to IDLE on its accepted beat with lasti=1.
REQ-024 SHALL, in LOCKED with the locked source deasserting vldi, accept nothing (bubble) and keep the lock.
REQ-025 SHALL treat a single-beat packet (lasti=1 on first beat) as IDLE->IDLE with ptr advanced.
REQ-026 SHALL wrap ptr from N_SRC-1 to 0.

Reset
REQ-027 SHALL on rst: vldo=0, lasto=0, datao=0, grant_id=0, state=IDLE, ptr=N_SRC-1 (source 0 has first priority).
REQ-028 SHALL, if rst asserts mid-packet, drop the lock and discard the held beat; no partial-packet recovery.
REQ-029 SHALL hold all rdyi=0 while rst is high.

Configuration
REQ-030 SHALL honour macro XSW_ARB_PKT_LOCK_EN: defined = lock mode (REQ-022..024); undefined = per-beat arbitration, lasti only forwarded to lasto, LOCKED state absent.

Structure
REQ-031 SHALL take the arbiter state enum (IDLE, LOCKED) and the index-width helper constant from shared package xsw_pkg.
REQ-032 SHALL place the rotate-priority pick in sub-module xsw_rr_pick (inputs request vector and ptr; outputs one-hot grant and index), combinational only.

Verification
REQ-033 SHALL cover: after reset, vldi=4'b1111, all lasti=1, rdyo=1 -> grant_id sequence 0,1,2,3,0 on consecutive cycles, vldo=1 from cycle 2.
REQ-034 SHALL cover: lock on, src2 sends 3-beat packet (last on beat 3) while src0/src1 valid -> grant_id 2,2,2 then 0; no interleave.
REQ-035 SHALL cover: rdyo=0 for 5 cycles with vldo=1, datao=16'hA5A5 -> datao stable, all rdyi=0, resume on rdyo=1 with no loss/duplication.
REQ-036 SHALL cover: lock on, src1 drops vldi for 2 cycles mid-packet with src3 valid -> 2 bubbles, src3 not granted until src1 lasti beat accepted.
REQ-037 SHALL cover: rst asserted while LOCKED on src3 -> next cycle vldo=0, state IDLE, first grant after release to src0 if valid.
REQ-038 SHALL cover: macro undefined, src0 and src1 valid with lasti=0 -> grant_id alternates 0,1,0,1.
